// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the core MEM stage
// and L2; 32-bit word accesses from the core, 128-bit block transfers to/from L2.
module l1_dcache #(
    parameter int BLOCKS = 8,
    parameter int TAGLEN = 25,
    parameter int CNTW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            proc_read,
    input  logic            proc_write,
    input  logic [29:0]     proc_addr,
    input  logic [31:0]     proc_wdata,
    output logic [31:0]     proc_rdata,
    output logic            proc_stall,
    output logic            l2_read,
    output logic            l2_write,
    output logic [29:0]     l2_addr,
    output logic [127:0]    l2_wdata,
    input  logic [127:0]    l2_rdata,
    input  logic            l2_ready,
    output logic [CNTW-1:0] hit_cnt,
    output logic [CNTW-1:0] miss_cnt
);
    localparam int IDXW = $clog2(BLOCKS);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t              r_state;
    logic [127:0]        r_data [BLOCKS];
    logic [TAGLEN-1:0]   r_tag  [BLOCKS];
    logic [BLOCKS-1:0]   r_valid;
    logic [BLOCKS-1:0]   r_dirty;
    logic                r_l2_read;
    logic                r_l2_write;
    logic [29:0]         r_l2_addr;
    logic [127:0]        r_l2_wdata;
    logic [CNTW-1:0]     r_hit_cnt;
    logic [CNTW-1:0]     r_miss_cnt;
    logic                r_refill;

    logic [IDXW-1:0]     w_idx;
    logic [TAGLEN-1:0]   w_tag;
    logic [1:0]          w_word;
    logic                w_req;
    logic                w_hit;
    logic                w_store;
    logic [127:0]        w_line;
    logic [29:0]         w_fill_addr;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [127:0] merge_word(input logic [127:0] line,
                                                input logic [1:0]   w,
                                                input logic [31:0]  d);
        logic [127:0] r;
        r = line;
        r[{w, 5'b0} +: 32] = d;
        return r;
    endfunction

    assign w_idx       = proc_addr[IDXW+1:2];
    assign w_tag       = proc_addr[29:IDXW+2];
    assign w_word      = proc_addr[1:0];
    assign w_req       = proc_read | proc_write;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store     = proc_write & ~proc_read;
    assign w_line      = r_data[w_idx];
    assign w_fill_addr = {proc_addr[29:2], 2'b00};

    // Stall is forced low while reset is held so a pending request cannot look stuck.
    assign proc_stall = reset & ((r_state != COMPARE) | (w_req & ~w_hit));
    assign proc_rdata = w_line[{w_word, 5'b0} +: 32];

    // Requests drop in the l2_ready cycle so L2 never sees a stale request.
    assign l2_read  = r_l2_read  & ~l2_ready;
    assign l2_write = r_l2_write & ~l2_ready;
    assign l2_addr  = r_l2_addr;
    assign l2_wdata = r_l2_wdata;
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= COMPARE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_l2_read  <= 1'b0;
            r_l2_write <= 1'b0;
            r_l2_addr  <= '0;
            r_l2_wdata <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_refill   <= 1'b0;
            for (int i = 0; i < BLOCKS; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            case (r_state)
                COMPARE: begin
                    r_refill <= 1'b0;
                    if (w_req) begin
                        if (w_hit) begin
                            // The hit that completes a refill was already counted as a miss.
                            if (!r_refill) r_hit_cnt <= sat_inc(r_hit_cnt);
                            if (w_store) begin
                                r_data[w_idx]  <= merge_word(w_line, w_word, proc_wdata);
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_miss_cnt <= sat_inc(r_miss_cnt);
                            if (r_valid[w_idx] && r_dirty[w_idx]) begin
                                r_l2_write <= 1'b1;
                                r_l2_wdata <= w_line;
                                r_l2_addr  <= {r_tag[w_idx], w_idx, 2'b00};
                                r_state    <= WRITEBACK;
                            end else begin
                                r_l2_read <= 1'b1;
                                r_l2_addr <= w_fill_addr;
                                r_state   <= ALLOCATE;
                            end
                        end
                    end
                end
                WRITEBACK: begin
                    if (l2_ready) begin
                        r_l2_write <= 1'b0;
                        r_l2_read  <= 1'b1;
                        r_l2_addr  <= w_fill_addr;
                        r_state    <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (l2_ready) begin
                        r_data[w_idx]  <= l2_rdata;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_l2_read      <= 1'b0;
                        r_refill       <= 1'b1;
                        r_state        <= COMPARE;
                    end
                end
                default: r_state <= COMPARE;
            endcase
        end
    end
endmodule
